// File: rtl/vt100_rxfifo_pkg.sv
// Shared vt100 receive-FIFO constants: status word layout and drop counter sizing.
// Bit positions are mirrored in the firmware header; change both together.
package vt100_rxfifo_pkg;

    localparam int unsigned STATUS_W    = 32;
    localparam int unsigned STS_HEAD_LSB = 24;
    localparam int unsigned STS_VALID   = 16;
    localparam int unsigned STS_OVF     = 15;
    localparam int unsigned STS_AFULL   = 14;
    localparam int unsigned STS_FULL    = 13;
    localparam int unsigned STS_CNT_LSB = 0;
    localparam int unsigned STS_CNT_W   = 11;

    localparam int unsigned DROP_W = 8;
    localparam logic [DROP_W-1:0] DROP_MAX = '1;

    function automatic logic [STATUS_W-1:0] pack_status(
        input logic [7:0]           head,
        input logic                 valid,
        input logic                 ovf,
        input logic                 afull,
        input logic                 full,
        input logic [STS_CNT_W-1:0] cnt
    );
        logic [STATUS_W-1:0] s;
        s = '0;
        s[STS_HEAD_LSB +: 8]      = head;
        s[STS_VALID]              = valid;
        s[STS_OVF]                = ovf;
        s[STS_AFULL]              = afull;
        s[STS_FULL]               = full;
        s[STS_CNT_LSB +: STS_CNT_W] = cnt;
        return s;
    endfunction

endpackage

// File: rtl/vt100_rxfifo_if.sv
// UART-receiver / CPU-window side bundle of the vt100 receive FIFO.
// master = producer/consumer logic driving strobes, slave = the FIFO itself.
interface vt100_rxfifo_if #(
    parameter int DATA_W     = 8,
    parameter int DEPTH_LOG2 = 4
);
    import vt100_rxfifo_pkg::*;

    logic                   enq;
    logic [DATA_W-1:0]      din;
    logic                   deq;
    logic                   flush;
    logic                   clr_ovf;
    logic [DATA_W-1:0]      dout;
    logic                   empty;
    logic                   full;
    logic                   almost_full;
    logic [DEPTH_LOG2:0]    count;
    logic                   overflow;
    logic [DROP_W-1:0]      drop_cnt;
    logic [STATUS_W-1:0]    status;

    modport master (
        output enq, din, deq, flush, clr_ovf,
        input  dout, empty, full, almost_full, count, overflow, drop_cnt, status
    );

    modport slave (
        input  enq, din, deq, flush, clr_ovf,
        output dout, empty, full, almost_full, count, overflow, drop_cnt, status
    );

endinterface

// File: rtl/vt100_fifo_mem.sv
// FIFO storage: one synchronous write port, one asynchronous read port, no reset.
// Write visible on the read port right after the writing edge.
module vt100_fifo_mem #(
    parameter int DATA_W     = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [DEPTH_LOG2-1:0] waddr_i,
    input  logic [DATA_W-1:0]     wdata_i,
    input  logic [DEPTH_LOG2-1:0] raddr_i,
    output logic [DATA_W-1:0]     rdata_o
);

    logic [DATA_W-1:0] mem_q [2**DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/vt100_rxfifo.sv
// vt100 receive FIFO: full-depth pointers, FWFT head, occupancy/flags combinational from pointers.
// Enq on full is dropped (counted) unless a deq frees the slot the same cycle; deq on empty is ignored.
module vt100_rxfifo
    import vt100_rxfifo_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int DEPTH_LOG2 = 4,
    parameter int AFULL_LVL  = (1 << DEPTH_LOG2) - 2
) (
    input  logic          clk,
    input  logic          rst_n,
    vt100_rxfifo_if.slave bus
);

    localparam int PW    = DEPTH_LOG2 + 1;
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic              ovf_q, ovf_d;
    logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;
    logic              arm_q;

    logic [PW-1:0]     count;
    logic              empty, full, almost_full;
    logic              deq_acc, enq_acc, enq_drop, flush_go, clr_go;
    logic [DATA_W-1:0] rdata, dout;

    assign count       = wr_ptr_q - rd_ptr_q;
    assign empty       = (count == '0);
    assign full        = (count == PW'(DEPTH));
    assign almost_full = (count >= PW'(AFULL_LVL));

    // arm_q blocks the edge on which rst_n rises, so a release racing a
    // clock edge can never half-accept a strobe.
    assign flush_go = arm_q && bus.flush;
    assign clr_go   = arm_q && bus.clr_ovf;
    assign deq_acc  = arm_q && bus.deq && !empty && !bus.flush;
    assign enq_acc  = arm_q && bus.enq && (!full || deq_acc) && !bus.flush;
    assign enq_drop = arm_q && bus.enq && full && !deq_acc && !bus.flush;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        ovf_d      = ovf_q;
        drop_cnt_d = drop_cnt_q;

        if (flush_go) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (enq_acc) wr_ptr_d = wr_ptr_q + PW'(1);
            if (deq_acc) rd_ptr_d = rd_ptr_q + PW'(1);
        end

        // A drop in the clearing cycle must not be lost: it restarts the count at 1.
        if (enq_drop) begin
            ovf_d = 1'b1;
            if (clr_go) begin
                drop_cnt_d = DROP_W'(1);
            end else if (drop_cnt_q != DROP_MAX) begin
                drop_cnt_d = drop_cnt_q + DROP_W'(1);
            end
        end else if (clr_go) begin
            ovf_d      = 1'b0;
            drop_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            ovf_q      <= 1'b0;
            drop_cnt_q <= '0;
            arm_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            ovf_q      <= ovf_d;
            drop_cnt_q <= drop_cnt_d;
            arm_q      <= 1'b1;
        end
    end

    vt100_fifo_mem #(
        .DATA_W     (DATA_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_mem (
        .clk     (clk),
        .we_i    (enq_acc),
        .waddr_i (wr_ptr_q[DEPTH_LOG2-1:0]),
        .wdata_i (bus.din),
        .raddr_i (rd_ptr_q[DEPTH_LOG2-1:0]),
        .rdata_o (rdata)
    );

    // Storage is unreset, so the head is masked to keep dout/status clean when empty.
    assign dout = empty ? '0 : rdata;

    assign bus.dout        = dout;
    assign bus.empty       = empty;
    assign bus.full        = full;
    assign bus.almost_full = almost_full;
    assign bus.count       = count;
    assign bus.overflow    = ovf_q;
    assign bus.drop_cnt    = drop_cnt_q;
    assign bus.status      = pack_status(8'(dout), !empty, ovf_q, almost_full, full,
                                         STS_CNT_W'(count));

endmodule

// File: tb/tb_vt100_rxfifo.sv
// Scoreboard bench for vt100_rxfifo against a queue-based reference model.
module tb_vt100_rxfifo;

    localparam int DW    = 8;
    localparam int DL2   = 4;
    localparam int DEPTH = 16;
    localparam int AFULL = 14;

    typedef struct {
        int         cnt;
        logic [7:0] head;
        bit         ovf;
        int         drops;
    } snap_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    vt100_rxfifo_if #(.DATA_W(DW), .DEPTH_LOG2(DL2)) bus();

    vt100_rxfifo #(.DATA_W(DW), .DEPTH_LOG2(DL2), .AFULL_LVL(AFULL)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0] mq[$];
    logic [7:0] exp_d[$];
    snap_t      st_q[$];
    bit         m_ovf = 0;
    int         m_drops = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue plus overflow bookkeeping.
    task automatic cycle(input bit e, input logic [7:0] d, input bit q, input bit f, input bit c);
        bit    acc_q, acc_e, dropped;
        snap_t s;
        @(posedge clk);
        #2;
        bus.enq = e; bus.din = d; bus.deq = q; bus.flush = f; bus.clr_ovf = c;
        acc_q = 0; acc_e = 0; dropped = 0;
        if (f) begin
            mq.delete();
            exp_d.delete();
        end else begin
            acc_q = q && (mq.size() > 0);
            if (e) begin
                if (mq.size() - int'(acc_q) < DEPTH) acc_e = 1;
                else dropped = 1;
            end
            if (acc_q) void'(mq.pop_front());
            if (acc_e) begin
                mq.push_back(d);
                exp_d.push_back(d);
            end
        end
        if (dropped) begin
            m_ovf   = 1;
            m_drops = c ? 1 : ((m_drops < 255) ? m_drops + 1 : 255);
        end else if (c) begin
            m_ovf   = 0;
            m_drops = 0;
        end
        s.cnt   = mq.size();
        s.head  = (mq.size() > 0) ? mq[0] : 8'h00;
        s.ovf   = m_ovf;
        s.drops = m_drops;
        st_q.push_back(s);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 8'h00, 0, 0, 0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_empty"},  32'(bus.empty), 32'd1);
        chk({tag, "_full"},   32'(bus.full), 32'd0);
        chk({tag, "_afull"},  32'(bus.almost_full), 32'd0);
        chk({tag, "_count"},  32'(bus.count), 32'd0);
        chk({tag, "_ovf"},    32'(bus.overflow), 32'd0);
        chk({tag, "_drop"},   32'(bus.drop_cnt), 32'd0);
        chk({tag, "_dout"},   32'(bus.dout), 32'd0);
        chk({tag, "_status"}, bus.status, 32'd0);
    endtask

    // State monitor: one model snapshot per clock, compared just after the edge.
    initial begin
        snap_t      s;
        logic [31:0] st;
        forever begin
            @(posedge clk);
            #1;
            if (st_q.size() > 0) begin
                s  = st_q.pop_front();
                st = {s.head, 7'b0, 1'(s.cnt != 0), 1'(s.ovf), 1'(s.cnt >= AFULL),
                      1'(s.cnt == DEPTH), 2'b0, 11'(s.cnt)};
                chk("count",    32'(bus.count), 32'(s.cnt));
                chk("empty",    32'(bus.empty), 32'(s.cnt == 0));
                chk("full",     32'(bus.full), 32'(s.cnt == DEPTH));
                chk("afull",    32'(bus.almost_full), 32'(s.cnt >= AFULL));
                chk("overflow", 32'(bus.overflow), 32'(s.ovf));
                chk("drop_cnt", 32'(bus.drop_cnt), 32'(s.drops));
                chk("dout",     32'(bus.dout), 32'(s.head));
                chk("status",   bus.status, st);
            end
        end
    end

    // Data monitor: every pop the DUT presents is matched against the scoreboard.
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && bus.deq && !bus.empty && !bus.flush) begin
                if (exp_d.size() == 0) begin
                    chk("pop_unexpected", 32'(bus.dout), 32'hFFFF_FFFF);
                end else begin
                    e = exp_d.pop_front();
                    chk("pop_data", 32'(bus.dout), 32'(e));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.enq = 0; bus.din = '0; bus.deq = 0; bus.flush = 0; bus.clr_ovf = 0;
        #1;
        chk_reset_outputs("por");
        #22;
        rst_n = 1'b1;
        idle(2);

        // deq on empty does nothing
        cycle(0, 8'h00, 1, 0, 0);
        idle(1);

        // fill 0x00..0x0F then drain in order
        for (int i = 0; i < 16; i++) cycle(1, 8'(i), 0, 0, 0);
        for (int i = 0; i < 16; i++) cycle(0, 8'h00, 1, 0, 0);
        idle(1);

        // refill, three drops, then enq+deq while full
        for (int i = 0; i < 16; i++) cycle(1, 8'($urandom_range(0, 255)), 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle(1, 8'hEE, 0, 0, 0);
        cycle(1, 8'hAA, 1, 0, 0);
        for (int i = 0; i < 16; i++) cycle(0, 8'h00, 1, 0, 0);
        idle(1);

        // flush with enq and deq asserted, overflow retained
        for (int i = 0; i < 5; i++) cycle(1, 8'(8'h40 + i), 0, 0, 0);
        cycle(1, 8'h99, 1, 1, 0);
        idle(1);

        // clr_ovf colliding with a drop, then saturate the drop counter
        for (int i = 0; i < 16; i++) cycle(1, 8'(8'h80 + i), 0, 0, 0);
        cycle(1, 8'h11, 0, 0, 1);
        for (int i = 0; i < 300; i++) cycle(1, 8'h22, 0, 0, 0);
        cycle(0, 8'h00, 0, 0, 1);
        cycle(0, 8'h00, 0, 1, 0);
        idle(1);

        // enq+deq on empty, then 40 pairs across pointer wrap
        cycle(1, 8'h5A, 1, 0, 0);
        for (int i = 0; i < 40; i++) cycle(1, 8'($urandom_range(0, 255)), 1, 0, 0);
        cycle(0, 8'h00, 1, 0, 0);
        idle(1);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 99) < 55), 8'($urandom_range(0, 255)),
                  ($urandom_range(0, 99) < 45), ($urandom_range(0, 99) < 2),
                  ($urandom_range(0, 99) < 3));
        end
        cycle(0, 8'h00, 0, 1, 1);
        idle(1);

        // async reset mid-burst with 9 entries held
        for (int i = 0; i < 9; i++) cycle(1, 8'(8'hC0 + i), 0, 0, 0);
        idle(1);
        @(posedge clk);
        #3;
        chk("pre_reset_count", 32'(bus.count), 32'd9);
        rst_n = 1'b0;
        mq.delete(); exp_d.delete(); m_ovf = 0; m_drops = 0;
        #1;
        chk_reset_outputs("arst");
        #9;
        rst_n = 1'b1;
        idle(2);
        cycle(1, 8'h5C, 0, 0, 0);
        cycle(0, 8'h00, 1, 0, 0);
        idle(3);

        chk("scoreboard_drained", 32'(exp_d.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
